// File: rtl/decoder_pkg.sv
// Shared types and widths for the 2-to-4 decoder sequencer path.
package decoder_pkg;

   localparam int unsigned CODE_W = 2;
   localparam int unsigned OUT_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } dec_state_t;

endpackage

// File: rtl/decoder_2_to_4.sv
// Combinational 2-to-4 one-hot decoder with an active-high enable.
module decoder_2_to_4
   import decoder_pkg::*;
(
   input  logic              enable,
   input  logic [CODE_W-1:0] in,
   output logic [OUT_W-1:0]  out
);

   assign out = enable ? (OUT_W'(1) << in) : '0;

endmodule

// File: rtl/decoder_2_to_4_sequencer.sv
// Accepts 2-bit codes over valid/ready, buffers one, and emits each as a
// timed one-hot strobe followed by an idle gap.
module decoder_2_to_4_sequencer
   import decoder_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in,
   output logic [OUT_W-1:0]  out,
   output logic              busy,
   output logic              done
);

   localparam int unsigned HG_MAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_MAX = (HG_MAX > 2) ? HG_MAX : 2;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   dec_state_t        r_state,      w_state_nxt;
   logic [CNT_W-1:0]  r_cnt,        w_cnt_nxt;
   logic [CODE_W-1:0] r_cur_code,   w_cur_code_nxt;
   logic              r_pend_valid, w_pend_valid_nxt;
   logic [CODE_W-1:0] r_pend_code,  w_pend_code_nxt;
   logic              w_accept;
   logic              w_next_step;
   logic              w_dec_en;

   assign in_ready = enable && !reset && !r_pend_valid;
   assign w_accept = in_valid && in_ready;

   // Outputs derive only from registered state, so they are glitch-free.
   assign w_dec_en = (r_state == DRIVE);
   assign busy     = (r_state != IDLE);
   assign done     = (r_state == DRIVE) && (r_cnt == '0);

   decoder_2_to_4 u_dec (
      .enable (w_dec_en),
      .in     (r_cur_code),
      .out    (out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_cur_code   <= '0;
         r_pend_valid <= 1'b0;
         r_pend_code  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_cur_code   <= w_cur_code_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_pend_code  <= w_pend_code_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_cur_code_nxt   = r_cur_code;
      w_pend_valid_nxt = r_pend_valid;
      w_pend_code_nxt  = r_pend_code;
      w_next_step      = 1'b0;

      if (!enable) begin
         w_state_nxt      = IDLE;
         w_cnt_nxt        = '0;
         w_pend_valid_nxt = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  w_cur_code_nxt = in;
                  w_cnt_nxt      = HOLD_LOAD;
                  w_state_nxt    = DRIVE;
               end
            end
            DRIVE: begin
               if (r_cnt != '0) begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end else if (GAP_CYCLES > 0) begin
                  w_cnt_nxt   = GAP_LOAD;
                  w_state_nxt = GAP;
               end else begin
                  w_next_step = 1'b1;
               end
            end
            GAP: begin
               if (r_cnt != '0) begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end else begin
                  w_next_step = 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         endcase

         // Pending code wins; an accept on this cycle bypasses the empty buffer.
         if (w_next_step) begin
            if (r_pend_valid) begin
               w_cur_code_nxt   = r_pend_code;
               w_pend_valid_nxt = 1'b0;
               w_cnt_nxt        = HOLD_LOAD;
               w_state_nxt      = DRIVE;
            end else if (w_accept) begin
               w_cur_code_nxt = in;
               w_cnt_nxt      = HOLD_LOAD;
               w_state_nxt    = DRIVE;
            end else begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
            end
         end else if (w_accept && (r_state != IDLE)) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_code_nxt  = in;
         end
      end
   end

endmodule

// File: tb/tb_decoder_2_to_4_sequencer.sv
// Scoreboard bench: stimulus queues expected strobes, a monitor checks them.
module tb_decoder_2_to_4_sequencer;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in;
   logic [3:0] out;
   logic       busy;
   logic       done;

   typedef struct {
      logic [3:0] code_oh;
      int         start;
      int         len;
      bit         has_done;
   } exp_t;

   exp_t sb[$];
   int   cyc       = 0;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   decoder_2_to_4_sequencer #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in       (in),
      .out      (out),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
   endtask

   task automatic wait_cyc(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   // Strobe monitor: each new one-hot value pops the next expected strobe.
   initial begin : monitor
      logic [3:0] prev;
      int         len;
      int         done_cnt;
      logic       done_last;
      bit         active;
      exp_t       cur;
      prev = '0; active = 0; len = 0; done_cnt = 0; done_last = 0;
      forever begin
         @(negedge clk);
         if (active && (out != prev)) begin
            check("strobe_len", len, cur.len);
            check("done_count", done_cnt, cur.has_done ? 1 : 0);
            if (cur.has_done) check("done_last", {31'd0, done_last}, 1);
            active = 0;
         end
         if ((out != 4'b0000) && (out != prev)) begin
            if (sb.size() == 0) begin
               check("unexpected_strobe", out, 0);
            end else begin
               cur = sb.pop_front();
               check("strobe_out", out, cur.code_oh);
               check("strobe_start", cyc, cur.start);
               active = 1; len = 0; done_cnt = 0;
            end
         end
         if (active) begin
            len++;
            if (done) done_cnt++;
            done_last = done;
         end else if (done === 1'b1) begin
            check("stray_done", done, 0);
         end
         prev = out;
      end
   end

   // Single accept of code 2 from IDLE, with cycle-exact checks.
   task automatic single_code();
      int k;
      in = 2'b10; in_valid = 1'b1; k = cyc + 1;
      sb.push_back('{4'b0100, k, 4, 1'b1});
      @(negedge clk); in_valid = 1'b0;
      check("s1_out_k1", out, 4'b0100);
      check("s1_busy_k1", busy, 1);
      wait_cyc(k + 2);
      check("s1_done_early", done, 0);
      wait_cyc(k + 3);
      check("s1_done", done, 1);
      check("s1_out_k4", out, 4'b0100);
      wait_cyc(k + 4);
      check("s1_out_gap", out, 0);
      check("s1_busy_gap", busy, 1);
      wait_cyc(k + 5);
      check("s1_idle_busy", busy, 0);
      check("s1_idle_ready", in_ready, 1);
   endtask

   initial begin : stim
      int k;
      reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in = 2'b00;

      @(negedge clk);
      check("rst_out", out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", in_ready, 0);
      @(negedge clk); reset = 1'b0;
      #1 check("post_rst_ready", in_ready, 1);
      @(negedge clk);

      // Reset then single code
      single_code();

      // Back-to-back via the pending register
      @(negedge clk);
      in = 2'b00; in_valid = 1'b1; k = cyc + 1;
      sb.push_back('{4'b0001, k, 4, 1'b1});
      @(negedge clk); in = 2'b11;
      sb.push_back('{4'b1000, k + 5, 4, 1'b1});
      @(negedge clk); in_valid = 1'b0;
      for (int c = k + 1; c <= k + 4; c++) begin
         wait_cyc(c);
         check("b2b_ready_full", in_ready, 0);
      end
      wait_cyc(k + 5);
      check("b2b_ready_drained", in_ready, 1);
      check("b2b_second_out", out, 4'b1000);
      wait_cyc(k + 10);
      check("b2b_idle", busy, 0);

      // Third code held while pending is full
      @(negedge clk);
      in = 2'b00; in_valid = 1'b1; k = cyc + 1;
      sb.push_back('{4'b0001, k, 4, 1'b1});
      @(negedge clk); in = 2'b01;
      sb.push_back('{4'b0010, k + 5, 4, 1'b1});
      @(negedge clk); in = 2'b10;
      sb.push_back('{4'b0100, k + 10, 4, 1'b1});
      for (int c = k + 1; c <= k + 4; c++) begin
         wait_cyc(c);
         #1 check("three_ready_blocked", in_ready, 0);
      end
      wait_cyc(k + 5);
      #1 check("three_ready_open", in_ready, 1);
      wait_cyc(k + 6); in_valid = 1'b0;
      wait_cyc(k + 15);
      check("three_idle", busy, 0);

      // Accept on the last GAP cycle with pending empty
      @(negedge clk);
      in = 2'b00; in_valid = 1'b1; k = cyc + 1;
      sb.push_back('{4'b0001, k, 4, 1'b1});
      @(negedge clk); in_valid = 1'b0;
      wait_cyc(k + 4);
      check("lastgap_out", out, 0);
      in = 2'b01; in_valid = 1'b1;
      sb.push_back('{4'b0010, k + 5, 4, 1'b1});
      #1 check("lastgap_ready", in_ready, 1);
      wait_cyc(k + 5); in_valid = 1'b0;
      check("lastgap_next_out", out, 4'b0010);
      wait_cyc(k + 10);
      check("lastgap_idle", busy, 0);

      // Abort with enable low during the 2nd DRIVE cycle
      @(negedge clk);
      in = 2'b11; in_valid = 1'b1; k = cyc + 1;
      sb.push_back('{4'b1000, k, 2, 1'b0});
      @(negedge clk); in = 2'b01;
      @(negedge clk); in_valid = 1'b0; enable = 1'b0;
      #1 check("abort_ready_low", in_ready, 0);
      wait_cyc(k + 2);
      check("abort_out", out, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_ready_still_low", in_ready, 0);
      @(negedge clk); enable = 1'b1;
      wait_cyc(k + 5);
      check("abort_pending_dropped", busy, 0);

      // Reset pulse during GAP with a pending code held
      @(negedge clk);
      in = 2'b10; in_valid = 1'b1; k = cyc + 1;
      sb.push_back('{4'b0100, k, 4, 1'b1});
      @(negedge clk); in = 2'b01;
      @(negedge clk); in_valid = 1'b0;
      wait_cyc(k + 4);
      check("mrst_in_gap", busy, 1);
      reset = 1'b1;
      #1 check("mrst_ready", in_ready, 0);
      wait_cyc(k + 5); reset = 1'b0;
      check("mrst_out", out, 0);
      check("mrst_busy", busy, 0);
      check("mrst_done", done, 0);
      wait_cyc(k + 7);
      check("mrst_pending_dropped", busy, 0);
      single_code();

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/decoder_2_to_4_sequencer.md
# decoder_2_to_4_sequencer

Sequenced 2-to-4 decoder: the consumer end of the 4-to-2 priority encoder path. It accepts 2-bit codes over a valid/ready handshake, buffers one code, and drives the matching one-hot line for a programmable number of cycles, followed by a programmable idle gap. It sits downstream of the priority encoder and turns each encoded request into a timed one-hot strobe for four consumers.

## Interface
- HOLD_CYCLES, 4: cycles each one-hot output is driven; legal range ≥1.
- GAP_CYCLES, 1: cycles `out` = 0 between consecutive strobes; legal range ≥0.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  1  active-high block enable.
- in_valid  input  1  `in` carries a code.
- in_ready  output  1  block can accept a code; combinational `= enable && !reset && !pend_valid`.
- in  input  2  code to decode.
- out  output  4  one-hot strobe `1 << code`; 4'b0000 when not driving.
- busy  output  1  high in DRIVE or GAP.
- done  output  1  one-cycle pulse on the last DRIVE cycle of each strobe.

## Operation
- Accept occurs on a rising edge where `in_valid && in_ready`.
- States: IDLE, DRIVE, GAP; down-counter `cnt`; one-entry pending register (`pend_valid`, `pend_code`); active code register `cur_code`.
- IDLE: an accept loads `cur_code`, sets `cnt = HOLD_CYCLES-1`, and moves to DRIVE. The pending register is not used.
- DRIVE: `out = 1 << cur_code`. Decrement `cnt`. When `cnt == 0`, assert `done`. Then:
  - if GAP_CYCLES > 0, go to GAP with `cnt = GAP_CYCLES-1`;
  - otherwise take the next-code step.
- GAP: `out` = 0. Decrement `cnt`. When `cnt == 0`, take the next-code step.
- Next-code step:
  - if `pend_valid`, load `pend_code`, clear `pend_valid`, go to DRIVE;
  - else if an accept occurs this cycle, load `in` directly and go to DRIVE;
  - else go to IDLE.
- Accept while in DRIVE or GAP, other than on a next-code cycle with the pending register empty: the code is written to the pending register.
- Simultaneous pending pop and accept: impossible, because `in_ready` = 0 whenever `pend_valid` = 1.
- `enable` deasserted in any state:
  - on the next edge: state → IDLE, `pend_valid` cleared, `cnt` cleared;
  - `out` = 0, `busy` = 0, `done` = 0 from the following cycle;
  - an aborted strobe never pulses `done`.
- Reset mid-operation: same effect as `enable` low, with priority over everything else.

## Timing
- Reset values: `out` = 4'b0000, `busy` = 0, `done` = 0, state IDLE, `pend_valid` = 0, `cnt` = 0. `in_ready` = 0 while `reset` is high.
- Latency: accept at edge k (from IDLE) → `out` one-hot during cycles k+1 … k+HOLD_CYCLES.
- `done` is high in cycle k+HOLD_CYCLES only.
- Back-to-back strobe period is HOLD_CYCLES + GAP_CYCLES cycles, with no bubble when a pending code exists.
- `out`, `busy` and `done` are registered (driven from state, `cnt` and `cur_code`).
- `in_ready` is the only combinational output.
- `cnt` width: `$clog2(max(HOLD_CYCLES, GAP_CYCLES, 2))`.

## Structure
- Shared package `decoder_pkg`:
  - state enum `dec_state_t` {IDLE, DRIVE, GAP};
  - constants `CODE_W` = 2 and `OUT_W` = 4.
- Sub-module `decoder_2_to_4`: purely combinational, ports `enable`, `in[1:0]`, `out[3:0]`. Instantiated on `cur_code`, with its `enable` = (state == DRIVE).
- Sequencer FSM, counter and pending register live in the top module.

## Test plan
All scenarios use HOLD_CYCLES = 4, GAP_CYCLES = 1.
- Reset, then a single code: reset 2 cycles, then `in` = 2'b10 with `in_valid` for one accept at edge k. Required response:
  - `out` = 4'b0100 in cycles k+1..k+4;
  - `done` = 1 at k+4;
  - `out` = 0 at k+5;
  - IDLE and `busy` = 0 at k+6.
- Back-to-back: accept 2'b00, then 2'b11 on the next edge (goes to the pending register). Required response:
  - `out` = 0001 for 4 cycles, 0000 for 1 cycle, 1000 for 4 cycles;
  - `in_ready` = 0 while pending is full.
- Third code while pending is full: hold `in_valid` = 1 with 2'b01. Required response:
  - no accept until the pending register drains;
  - `out` sequence 0001, 0010, 0100 … in accept order, with no code lost.
- Accept on the last GAP cycle with pending empty: accept 2'b01 then. Required response: `out` = 0010 on the very next cycle.
- Abort: drop `enable` during the 2nd DRIVE cycle of 2'b11, with a pending code held. Required response:
  - `out` = 0 and `busy` = 0 one cycle later;
  - no `done` pulse;
  - the pending code is discarded;
  - `in_ready` = 0 while `enable` is low.
- Mid-strobe reset: assert `reset` for 1 cycle during GAP. Required response:
  - all outputs return to reset values on the next cycle;
  - a fresh accept afterwards behaves exactly as in the first scenario.
